// File: rtl/tq_odd_post_4_pkg.sv
// Shared transform/quant constants and the control word carried beside the multiplier.
// Pure declarations: no latency, no backpressure.
package tq_odd_post_4_pkg;

    localparam int IN_W_DEF    = 28;
    localparam int OUT_W_DEF   = 16;
    localparam int MCM_LAT_DEF = 2;
    localparam int SHIFT_W     = 5;

    // 4-point transform at 8-bit depth
    localparam int LOG2N = 2;
    localparam int BD    = 8;

    localparam int FWD_SHIFT1 = LOG2N - 1 + BD - 8;
    localparam int FWD_SHIFT2 = LOG2N + 6;
    localparam int INV_SHIFT1 = 7;
    localparam int INV_SHIFT2 = 20 - BD;

    localparam int OUT_MAX = (1 << (OUT_W_DEF - 1)) - 1;
    localparam int OUT_MIN = -(1 << (OUT_W_DEF - 1));

    typedef struct packed {
        logic               vld;
        logic               first;
        logic [SHIFT_W-1:0] shift;
    } ctrl_t;

endpackage

// File: rtl/tq_odd_post_4_rnd_clip_lane.sv
// One lane: round-add (stage A) then arithmetic shift and clip (stage B); 2 cycles.
// No backpressure; each stage loads only on its enable, res holds otherwise.
module tq_odd_post_4_rnd_clip_lane
    import tq_odd_post_4_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_a,
    input  logic [SHIFT_W-1:0]       shift,
    input  logic signed [IN_W-1:0]   m,
    input  logic                     en_b,
    output logic signed [OUT_W-1:0]  res,
    output logic                     sat
);

    localparam int SW = IN_W + 1;
    localparam logic signed [SW-1:0] HI = SW'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [SW-1:0] LO = -HI - SW'(1);

    logic signed [SW-1:0]  rnd;
    logic signed [SW-1:0]  sum_q;
    logic [SHIFT_W-1:0]    sh_q;
    logic signed [SW-1:0]  shr;
    logic signed [SW-1:0]  clip;

    always_comb begin
        rnd = '0;
        if (shift != '0) begin
            rnd = SW'(1) <<< (shift - SHIFT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
            sh_q  <= '0;
        end else if (en_a) begin
            sum_q <= SW'(m) + rnd;
            sh_q  <= shift;
        end
    end

    // sat is combinational off stage A so the top can count it on the same edge res loads
    always_comb begin
        shr  = sum_q >>> sh_q;
        clip = shr;
        sat  = 1'b0;
        if (shr > HI) begin
            clip = HI;
            sat  = 1'b1;
        end else if (shr < LO) begin
            clip = LO;
            sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res <= '0;
        end else if (en_b) begin
            res <= clip[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/tq_odd_post_4.sv
// Odd-part multiplier post-stage: round, shift, clip 4 lanes; block framing; saturation stat.
// Latency MCM_LAT+2 from i_valid to o_valid; full throughput, no backpressure.
module tq_odd_post_4
    import tq_odd_post_4_pkg::*;
#(
    parameter int IN_W    = IN_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int MCM_LAT = MCM_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic                     i_first,
    input  logic [SHIFT_W-1:0]       i_shift,
    input  logic signed [IN_W-1:0]   i_m_0,
    input  logic signed [IN_W-1:0]   i_m_1,
    input  logic signed [IN_W-1:0]   i_m_2,
    input  logic signed [IN_W-1:0]   i_m_3,
    input  logic                     i_sat_clr,
    output logic                     o_valid,
    output logic                     o_last,
    output logic signed [OUT_W-1:0]  o_0,
    output logic signed [OUT_W-1:0]  o_1,
    output logic signed [OUT_W-1:0]  o_2,
    output logic signed [OUT_W-1:0]  o_3,
    output logic [15:0]              o_sat_cnt
);

    ctrl_t                   dl [MCM_LAT];
    ctrl_t                   tap;
    logic                    vld_a;
    logic                    first_a;
    logic [1:0]              cnt;
    logic [1:0]              idx;
    logic [3:0]              lane_sat;
    logic signed [IN_W-1:0]  m_arr   [4];
    logic signed [OUT_W-1:0] res_arr [4];

    assign tap = dl[MCM_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MCM_LAT; i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0] <= '{vld: i_valid, first: i_valid & i_first, shift: i_shift};
            for (int i = 1; i < MCM_LAT; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_a   <= 1'b0;
            first_a <= 1'b0;
        end else begin
            vld_a   <= tap.vld;
            first_a <= tap.first;
        end
    end

    assign m_arr[0] = i_m_0;
    assign m_arr[1] = i_m_1;
    assign m_arr[2] = i_m_2;
    assign m_arr[3] = i_m_3;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        tq_odd_post_4_rnd_clip_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en_a  (tap.vld),
            .shift (tap.shift),
            .m     (m_arr[k]),
            .en_b  (vld_a),
            .res   (res_arr[k]),
            .sat   (lane_sat[k])
        );
    end

    assign o_0 = res_arr[0];
    assign o_1 = res_arr[1];
    assign o_2 = res_arr[2];
    assign o_3 = res_arr[3];

    // cnt holds the index the next beat takes unless that beat restarts the block
    assign idx = first_a ? 2'd0 : cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            cnt       <= '0;
            o_sat_cnt <= '0;
        end else begin
            o_valid <= vld_a;
            o_last  <= vld_a && (idx == 2'd3);
            if (vld_a) begin
                cnt <= idx + 2'd1;
            end
            if (i_sat_clr) begin
                o_sat_cnt <= '0;
            end else if (vld_a && (|lane_sat) && (o_sat_cnt != 16'hFFFF)) begin
                o_sat_cnt <= o_sat_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tq_odd_post_4.sv
// Bench for tq_odd_post_4: directed and random beats against a floor-division reference model.
module tb_tq_odd_post_4;

    localparam int N = 128;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_valid = 1'b0;
    logic               i_first = 1'b0;
    logic               i_sat_clr = 1'b0;
    logic [4:0]         i_shift = '0;
    logic signed [27:0] i_m_0 = '0;
    logic signed [27:0] i_m_1 = '0;
    logic signed [27:0] i_m_2 = '0;
    logic signed [27:0] i_m_3 = '0;
    logic               o_valid;
    logic               o_last;
    logic signed [15:0] o_0;
    logic signed [15:0] o_1;
    logic signed [15:0] o_2;
    logic signed [15:0] o_3;
    logic [15:0]        o_sat_cnt;

    int n_chk = 0;
    int n_fail = 0;

    bit                 st_v   [N];
    bit                 st_f   [N];
    bit                 st_clr [N];
    logic [4:0]         st_sh  [N];
    logic signed [27:0] st_m   [N][4];
    logic [81:0]        obs    [N];
    logic [81:0]        expv   [N];
    logic [81:0]        obs_rst;

    int          mpos;
    int          msat;
    logic [15:0] mo [4];

    always #5 clk = ~clk;

    tq_odd_post_4 dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_first   (i_first),
        .i_shift   (i_shift),
        .i_m_0     (i_m_0),
        .i_m_1     (i_m_1),
        .i_m_2     (i_m_2),
        .i_m_3     (i_m_3),
        .i_sat_clr (i_sat_clr),
        .o_valid   (o_valid),
        .o_last    (o_last),
        .o_0       (o_0),
        .o_1       (o_1),
        .o_2       (o_2),
        .o_3       (o_3),
        .o_sat_cnt (o_sat_cnt)
    );

    function automatic logic [15:0] rclip(input longint m, input int sh, output bit s);
        longint d, num, q;
        d   = longint'(1) << sh;
        num = m + ((sh == 0) ? longint'(0) : d / 2);
        q   = num / d;
        if ((num % d != 0) && (num < 0)) q = q - 1;
        s = 1'b0;
        if (q > 32767) begin
            q = 32767;
            s = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            s = 1'b1;
        end
        return q[15:0];
    endfunction

    function automatic longint rnd_m();
        if ($urandom_range(0, 1) == 1)
            return longint'($signed(28'($urandom)));
        return longint'($urandom_range(0, 200000)) - 100000;
    endfunction

    task automatic model_reset();
        mpos = 0;
        msat = 0;
        for (int k = 0; k < 4; k++) mo[k] = '0;
    endtask

    task automatic clear_stim();
        for (int c = 0; c < N; c++) begin
            st_v[c] = 0;
            st_f[c] = 0;
            st_clr[c] = 0;
            st_sh[c] = '0;
            for (int k = 0; k < 4; k++) st_m[c][k] = '0;
        end
    endtask

    task automatic set_beat(input int c, input bit f, input int sh,
                            input longint a, input longint b, input longint cc, input longint d);
        st_v[c]    = 1;
        st_f[c]    = f;
        st_sh[c]   = 5'(sh);
        st_m[c][0] = 28'(a);
        st_m[c][1] = 28'(b);
        st_m[c][2] = 28'(cc);
        st_m[c][3] = 28'(d);
    endtask

    // obs[c] is sampled just after the edge that closes cycle c; beat b surfaces at c = b+3
    task automatic drive_run(input int n, input int abort_at);
        for (int c = 0; c < n + 4; c++) begin
            i_valid   = (c < n) ? st_v[c] : 1'b0;
            i_first   = (c < n) ? st_f[c] : 1'b0;
            i_shift   = (c < n) ? st_sh[c] : 5'($urandom_range(0, 20));
            i_sat_clr = (c < n) ? st_clr[c] : 1'b0;
            if (c >= 2 && c - 2 < n && st_v[c-2]) begin
                i_m_0 = st_m[c-2][0];
                i_m_1 = st_m[c-2][1];
                i_m_2 = st_m[c-2][2];
                i_m_3 = st_m[c-2][3];
            end else begin
                i_m_0 = 28'($urandom);
                i_m_1 = 28'($urandom);
                i_m_2 = 28'($urandom);
                i_m_3 = 28'($urandom);
            end
            @(posedge clk);
            #1;
            obs[c] = {o_valid, o_last, o_0, o_1, o_2, o_3, o_sat_cnt};
            if (c == abort_at) begin
                #2;
                rst = 1'b0;
                #1;
                obs_rst = {o_valid, o_last, o_0, o_1, o_2, o_3, o_sat_cnt};
                break;
            end
        end
        i_valid = 0;
        i_first = 0;
        i_sat_clr = 0;
    endtask

    task automatic model_run(input int n);
        for (int c = 0; c < n + 4; c++) begin
            int b;
            int pos;
            bit vb, lst, anys, s;
            b = c - 3;
            vb = 0;
            lst = 0;
            anys = 0;
            if (b >= 0 && b < n) vb = st_v[b];
            if (vb) begin
                pos  = st_f[b] ? 0 : mpos;
                lst  = (pos == 3);
                mpos = (pos + 1) % 4;
                for (int k = 0; k < 4; k++) begin
                    mo[k] = rclip(longint'(st_m[b][k]), int'(st_sh[b]), s);
                    anys |= s;
                end
            end
            if (c < n && st_clr[c]) msat = 0;
            else if (vb && anys && msat < 65535) msat++;
            expv[c] = {vb, lst, mo[0], mo[1], mo[2], mo[3], 16'(msat)};
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if ({o_valid, o_last, o_0, o_1, o_2, o_3, o_sat_cnt} !== 82'd0) begin
            n_fail++;
            $display("FAIL reset_async got %h want 0", {o_valid, o_last, o_0, o_1, o_2, o_3, o_sat_cnt});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({o_valid, o_last, o_0, o_1, o_2, o_3, o_sat_cnt} !== 82'd0) begin
            n_fail++;
            $display("FAIL reset_release got %h want 0", {o_valid, o_last, o_0, o_1, o_2, o_3, o_sat_cnt});
        end
        model_reset();
    endtask

    task automatic test_basic();
        clear_stim();
        set_beat(0, 0, 7, 1000, -1000, 64, -64);
        drive_run(1, -1);
        model_run(1);
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if (obs[c] !== expv[c]) begin
                n_fail++;
                $display("FAIL basic c=%0d got %h want %h", c, obs[c], expv[c]);
            end
        end
        n_chk++;
        if (obs[3] !== {1'b1, 1'b0, 16'd8, 16'hFFF8, 16'd1, 16'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL basic_const got %h want 8/-8/1/0 sat0", obs[3]);
        end
    endtask

    task automatic test_sat_edges();
        clear_stim();
        set_beat(0, 0, 0, 5, -5, 32767, -32769);
        drive_run(1, -1);
        model_run(1);
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if (obs[c] !== expv[c]) begin
                n_fail++;
                $display("FAIL shift0 c=%0d got %h want %h", c, obs[c], expv[c]);
            end
        end
        n_chk++;
        if (obs[3] !== {1'b1, 1'b0, 16'd5, 16'hFFFB, 16'h7FFF, 16'h8000, 16'd1}) begin
            n_fail++;
            $display("FAIL shift0_const got %h want 5/-5/32767/-32768 sat1", obs[3]);
        end
        clear_stim();
        set_beat(0, 0, 12, 134217727, -134217728, 2048, -2049);
        drive_run(1, -1);
        model_run(1);
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if (obs[c] !== expv[c]) begin
                n_fail++;
                $display("FAIL shift12 c=%0d got %h want %h", c, obs[c], expv[c]);
            end
        end
        n_chk++;
        if (obs[3] !== {1'b1, 1'b0, 16'h7FFF, 16'h8000, 16'd1, 16'hFFFF, 16'd2}) begin
            n_fail++;
            $display("FAIL shift12_const got %h want 32767/-32768/1/-1 sat2", obs[3]);
        end
    endtask

    task automatic test_back_to_back();
        int shs [4];
        shs = '{1, 8, 7, 12};
        clear_stim();
        for (int i = 0; i < 4; i++) set_beat(i, i == 0, shs[i], rnd_m(), rnd_m(), rnd_m(), rnd_m());
        drive_run(4, -1);
        model_run(4);
        for (int c = 0; c < 8; c++) begin
            n_chk++;
            if (obs[c] !== expv[c]) begin
                n_fail++;
                $display("FAIL b2b c=%0d got %h want %h", c, obs[c], expv[c]);
            end
        end
        n_chk++;
        if (obs[6][81:80] !== 2'b11 || obs[5][80] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_last got %b/%b want 11/0", obs[6][81:80], obs[5][80]);
        end
        clear_stim();
        set_beat(0, 1, 1, rnd_m(), rnd_m(), rnd_m(), rnd_m());
        set_beat(1, 0, 8, rnd_m(), rnd_m(), rnd_m(), rnd_m());
        set_beat(3, 0, 7, rnd_m(), rnd_m(), rnd_m(), rnd_m());
        set_beat(4, 0, 12, rnd_m(), rnd_m(), rnd_m(), rnd_m());
        drive_run(5, -1);
        model_run(5);
        for (int c = 0; c < 9; c++) begin
            n_chk++;
            if (obs[c] !== expv[c]) begin
                n_fail++;
                $display("FAIL b2b_bubble c=%0d got %h want %h", c, obs[c], expv[c]);
            end
        end
        n_chk++;
        if (obs[7][81:80] !== 2'b11 || obs[6][80] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_bubble_last got %b/%b want 11/0", obs[7][81:80], obs[6][80]);
        end
    endtask

    task automatic test_bubbles();
        clear_stim();
        set_beat(0, 1, 4, 1000, -3000, 77, 5);
        set_beat(2, 0, 3, -9, 900, 12345, -1);
        drive_run(3, -1);
        model_run(3);
        for (int c = 0; c < 7; c++) begin
            n_chk++;
            if (obs[c] !== expv[c]) begin
                n_fail++;
                $display("FAIL bubble c=%0d got %h want %h", c, obs[c], expv[c]);
            end
        end
        n_chk++;
        if ({obs[3][81], obs[4][81], obs[5][81]} !== 3'b101) begin
            n_fail++;
            $display("FAIL bubble_valid got %b want 101", {obs[3][81], obs[4][81], obs[5][81]});
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            clear_stim();
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 9) < 7)
                    set_beat(c, $urandom_range(0, 4) == 0, $urandom_range(0, 20),
                             rnd_m(), rnd_m(), rnd_m(), rnd_m());
                st_clr[c] = ($urandom_range(0, 19) == 0);
            end
            drive_run(60, -1);
            model_run(60);
            for (int c = 0; c < 64; c++) begin
                n_chk++;
                if (obs[c] !== expv[c]) begin
                    n_fail++;
                    $display("FAIL random r=%0d c=%0d got %h want %h", r, c, obs[c], expv[c]);
                end
            end
        end
    endtask

    task automatic test_sat_limit();
        int beats;
        beats = 65540;
        i_sat_clr = 1;
        @(posedge clk);
        #1;
        i_sat_clr = 0;
        i_m_0 = 28'sd134217727;
        i_m_1 = '0;
        i_m_2 = '0;
        i_m_3 = '0;
        i_shift = '0;
        i_first = 0;
        i_valid = 1;
        repeat (beats) @(posedge clk);
        #1;
        i_valid = 0;
        repeat (5) @(posedge clk);
        #1;
        msat = 65535;
        mpos = (mpos + beats) % 4;
        mo[0] = 16'h7FFF;
        for (int k = 1; k < 4; k++) mo[k] = '0;
        n_chk++;
        if ({o_valid, o_0, o_sat_cnt} !== {1'b0, 16'h7FFF, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL sat_fill got sat=%h o_0=%h want ffff/7fff", o_sat_cnt, o_0);
        end
        clear_stim();
        set_beat(0, 0, 0, 40000, 0, 0, 0);
        set_beat(2, 0, 0, 0, -40000, 0, 0);
        st_clr[5] = 1;
        drive_run(6, -1);
        model_run(6);
        for (int c = 0; c < 10; c++) begin
            n_chk++;
            if (obs[c] !== expv[c]) begin
                n_fail++;
                $display("FAIL sat_limit c=%0d got %h want %h", c, obs[c], expv[c]);
            end
        end
        n_chk++;
        if (obs[3][15:0] !== 16'hFFFF || obs[5][15:0] !== 16'h0000) begin
            n_fail++;
            $display("FAIL sat_clr_wins got %h/%h want ffff/0000", obs[3][15:0], obs[5][15:0]);
        end
    endtask

    task automatic test_reset_mid();
        clear_stim();
        for (int i = 0; i < 4; i++) set_beat(i, i == 0, 2, 300000, -7, 11, 4);
        drive_run(4, 4);
        model_run(4);
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if (obs[c] !== expv[c]) begin
                n_fail++;
                $display("FAIL pre_reset c=%0d got %h want %h", c, obs[c], expv[c]);
            end
        end
        n_chk++;
        if (obs_rst !== 82'd0) begin
            n_fail++;
            $display("FAIL reset_mid got %h want 0", obs_rst);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        clear_stim();
        for (int i = 0; i < 4; i++) set_beat(i, i == 0, 5, rnd_m(), rnd_m(), rnd_m(), rnd_m());
        drive_run(4, -1);
        model_run(4);
        for (int c = 0; c < 8; c++) begin
            n_chk++;
            if (obs[c] !== expv[c]) begin
                n_fail++;
                $display("FAIL post_reset c=%0d got %h want %h", c, obs[c], expv[c]);
            end
        end
        n_chk++;
        if (obs[6][81:80] !== 2'b11) begin
            n_fail++;
            $display("FAIL post_reset_last got %b want 11", obs[6][81:80]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat_edges();
        test_back_to_back();
        test_bubbles();
        test_random();
        test_sat_limit();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
